// File: rtl/in_event_fifo_if.sv
// Handshake bundle between the input-event producer, the FIFO and the CDC IN endpoint.
// The FIFO side uses modport slave; the producer/consumer side uses modport master.
interface in_event_fifo_if #(
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]  wr_data_i;
   logic        wr_valid_i;
   logic        wr_ready_o;
   logic [7:0]  rd_data_o;
   logic        rd_valid_o;
   logic        rd_ready_i;
   logic        usb_configured_i;
   logic [AW:0] level_o;
   logic        overflow_o;
   logic [7:0]  drop_count_o;

   modport slave (
      input  wr_data_i, wr_valid_i, rd_ready_i, usb_configured_i,
      output wr_ready_o, rd_data_o, rd_valid_o, level_o, overflow_o, drop_count_o
   );

   modport master (
      output wr_data_i, wr_valid_i, rd_ready_i, usb_configured_i,
      input  wr_ready_o, rd_data_o, rd_valid_o, level_o, overflow_o, drop_count_o
   );
endinterface

// File: rtl/in_event_fifo.sv
// First-word-fall-through byte FIFO from the arcade input event stream to the USB CDC IN port.
// Define IN_EVENT_FIFO_STATS_EN to build the saturating dropped-byte counter on drop_count_o.
module in_event_fifo #(
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   in_event_fifo_if.slave  bus
);

   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wp_q, wp_d;
   logic [AW:0] rp_q, rp_d;
   logic        ovf_q, ovf_d;
   logic        cfg;
   logic        empty, full;
   logic        push, drop, pop;

   assign cfg   = bus.usb_configured_i;
   assign empty = (wp_q == rp_q);
   assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);

   // Full is judged on registered pointers, so a same-cycle pop never rescues a write.
   assign push = bus.wr_valid_i & ~full & cfg;
   assign drop = bus.wr_valid_i &  full & cfg;
   assign pop  = bus.rd_valid_o & bus.rd_ready_i;

   assign bus.wr_ready_o = ~full | ~cfg;
   assign bus.rd_valid_o = ~empty & cfg;
   assign bus.rd_data_o  = mem_q[rp_q[AW-1:0]];
   assign bus.level_o    = wp_q - rp_q;
   assign bus.overflow_o = ovf_q;

   always_comb begin
      wp_d  = wp_q + {{AW{1'b0}}, push};
      rp_d  = cfg ? (rp_q + {{AW{1'b0}}, pop}) : wp_q;
      ovf_d = cfg & (ovf_q | drop);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wp_q  <= '0;
         rp_q  <= '0;
         ovf_q <= 1'b0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q <= '{default: '0};
      end else if (push) begin
         mem_q[wp_q[AW-1:0]] <= bus.wr_data_i;
      end
   end

`ifdef IN_EVENT_FIFO_STATS_EN
   logic [7:0] drop_q, drop_d;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_comb begin
      drop_d = drop_q;
      if (!cfg)
         drop_d = 8'h00;
      else if (drop)
         drop_d = sat_inc(drop_q);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) drop_q <= 8'h00;
      else       drop_q <= drop_d;
   end

   assign bus.drop_count_o = drop_q;
`else
   assign bus.drop_count_o = 8'h00;
`endif

endmodule

// File: tb/tb_in_event_fifo.sv
// Directed self-checking bench for in_event_fifo; expected drop counts follow IN_EVENT_FIFO_STATS_EN.
module tb_in_event_fifo;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   in_event_fifo_if #(.DEPTH(16)) bus();

   in_event_fifo #(.DEPTH(16)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Entered just after a negedge; holds the write through one rising edge.
   task automatic push(input logic [7:0] d);
      bus.wr_valid_i = 1'b1;
      bus.wr_data_i  = d;
      @(negedge clk);
      bus.wr_valid_i = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_level"},    32'(bus.level_o), 0);
      chk({tag, "_rdvalid"},  32'(bus.rd_valid_o), 0);
      chk({tag, "_rddata"},   32'(bus.rd_data_o), 0);
      chk({tag, "_wrready"},  32'(bus.wr_ready_o), 1);
      chk({tag, "_overflow"}, 32'(bus.overflow_o), 0);
      chk({tag, "_drops"},    32'(bus.drop_count_o), 0);
   endtask

   logic [7:0] d;
   int         exp_drop1, exp_drop2, exp_drop_sat;

   initial begin
`ifdef IN_EVENT_FIFO_STATS_EN
      exp_drop1 = 1; exp_drop2 = 2; exp_drop_sat = 255;
`else
      exp_drop1 = 0; exp_drop2 = 0; exp_drop_sat = 0;
`endif
      bus.wr_data_i        = 8'h00;
      bus.wr_valid_i       = 1'b0;
      bus.rd_ready_i       = 1'b0;
      bus.usb_configured_i = 1'b1;

      // Reset state
      #1 rst = 1'b1;
      #1 chk_reset_vals("reset");
      @(negedge clk);
      rst = 1'b0;

      // Single byte through
      push(8'h41);
      chk("t1_valid", 32'(bus.rd_valid_o), 1);
      chk("t1_data",  32'(bus.rd_data_o), 32'h41);
      chk("t1_level", 32'(bus.level_o), 1);
      bus.rd_ready_i = 1'b1;
      @(negedge clk);
      bus.rd_ready_i = 1'b0;
      chk("t1_valid_after_pop", 32'(bus.rd_valid_o), 0);
      chk("t1_level_after_pop", 32'(bus.level_o), 0);

      // Fill, overflow, drain
      for (int i = 0; i < 16; i++) push(8'(8'h41 + i));
      chk("t2_wrready_full", 32'(bus.wr_ready_o), 0);
      chk("t2_level_full",   32'(bus.level_o), 16);
      push(8'h51);
      chk("t2_overflow", 32'(bus.overflow_o), 1);
      chk("t2_level",    32'(bus.level_o), 16);
      chk("t2_drops",    32'(bus.drop_count_o), 32'(exp_drop1));
      bus.rd_ready_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("t2_drain_data", 32'(bus.rd_data_o), 32'(8'h41 + i));
         @(negedge clk);
      end
      bus.rd_ready_i = 1'b0;
      chk("t2_empty", 32'(bus.rd_valid_o), 0);

      // Write and pop while full: write is dropped
      for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
      bus.wr_valid_i = 1'b1;
      bus.wr_data_i  = 8'hAA;
      bus.rd_ready_i = 1'b1;
      @(negedge clk);
      bus.wr_valid_i = 1'b0;
      bus.rd_ready_i = 1'b0;
      chk("t3_level",    32'(bus.level_o), 15);
      chk("t3_overflow", 32'(bus.overflow_o), 1);
      chk("t3_wrready",  32'(bus.wr_ready_o), 1);
      chk("t3_drops",    32'(bus.drop_count_o), 32'(exp_drop2));
      bus.rd_ready_i = 1'b1;
      for (int i = 1; i < 16; i++) begin
         chk("t3_drain_data", 32'(bus.rd_data_o), 32'(8'h80 + i));
         @(negedge clk);
      end
      bus.rd_ready_i = 1'b0;
      chk("t3_empty", 32'(bus.level_o), 0);

      // Streaming across pointer wrap
      bus.rd_ready_i = 1'b1;
      for (int i = 0; i < 40; i++) begin
         d = 8'(i * 7 + 3);
         bus.wr_valid_i = 1'b1;
         bus.wr_data_i  = d;
         @(negedge clk);
         chk("t4_level", 32'(bus.level_o), 1);
         chk("t4_data",  32'(bus.rd_data_o), 32'(d));
      end
      bus.wr_valid_i = 1'b0;
      @(negedge clk);
      bus.rd_ready_i = 1'b0;
      chk("t4_level_end", 32'(bus.level_o), 0);

      // Flush on unconfigure
      for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
      chk("t5_level_loaded", 32'(bus.level_o), 5);
      bus.usb_configured_i = 1'b0;
      #1;
      chk("t5_valid_masked", 32'(bus.rd_valid_o), 0);
      chk("t5_wrready_uncfg", 32'(bus.wr_ready_o), 1);
      @(negedge clk);
      chk("t5_level_flushed", 32'(bus.level_o), 0);
      chk("t5_overflow_clr",  32'(bus.overflow_o), 0);
      chk("t5_drops_clr",     32'(bus.drop_count_o), 0);
      push(8'h99);
      chk("t5_write_ignored", 32'(bus.level_o), 0);
      bus.usb_configured_i = 1'b1;
      #1;
      chk("t5_valid_reconf", 32'(bus.rd_valid_o), 0);
      @(negedge clk);
      push(8'h62);
      chk("t5_first_valid", 32'(bus.rd_valid_o), 1);
      chk("t5_first_data",  32'(bus.rd_data_o), 32'h62);
      chk("t5_first_level", 32'(bus.level_o), 1);
      bus.rd_ready_i = 1'b1;
      @(negedge clk);
      bus.rd_ready_i = 1'b0;

      // Saturating drop counter, then async reset mid-burst
      for (int i = 0; i < 16; i++) push(8'(i));
      bus.wr_valid_i = 1'b1;
      for (int i = 0; i < 300; i++) begin
         bus.wr_data_i = 8'(i);
         @(negedge clk);
      end
      chk("t6_drops_sat", 32'(bus.drop_count_o), 32'(exp_drop_sat));
      chk("t6_overflow",  32'(bus.overflow_o), 1);
      chk("t6_level",     32'(bus.level_o), 16);
      #2 rst = 1'b1;
      #1 chk_reset_vals("t6_async_rst");
      @(negedge clk);
      bus.wr_valid_i = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_level_after_rst", 32'(bus.level_o), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
